ecc_mod_mul: RTL

//   Bit-serial interleaved modular multiplier: o_result = (x * y) mod prime.

---
 rtl/ecc_mod_mul.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ecc_mod_mul.sv
// Bit-serial interleaved modular multiplier: result = (x * y) mod p, MSB-first,
// one multiplier bit per clock, operand width selectable at 32/64/128/256 bits.
module ecc_mod_mul #(
    parameter int MAX_BITS = 256,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_x,
    input  logic [MAX_BITS-1:0] i_y,
    input  logic [MAX_BITS-1:0] i_prime,
    output logic                o_busy,
    output logic                o_done,
    output logic [MAX_BITS-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [MAX_BITS-1:0] r_x;
    logic [MAX_BITS-1:0] r_y;
    logic [MAX_BITS-1:0] r_p;
    logic [MAX_BITS-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_mode;

    logic [MAX_BITS-1:0] w_in_mask;
    logic [MAX_BITS-1:0] w_run_mask;
    logic [MAX_BITS:0]   w_dbl;
    logic [MAX_BITS:0]   w_p_ext;
    logic [MAX_BITS:0]   w_t;
    logic [MAX_BITS:0]   w_addend;
    logic [MAX_BITS:0]   w_sum;
    logic [MAX_BITS-1:0] w_u;
    logic [CNT_W-1:0]    w_cnt_init;

    // Width masks: one for the operands being latched, one for the op in flight.
    generate
        for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_mask
            assign w_in_mask[gi]  = (gi < (32 << i_mode));
            assign w_run_mask[gi] = (gi < (32 << r_mode));
        end
    endgenerate

    always_comb begin
        w_cnt_init = CNT_W'(31);
        case (i_mode)
            2'b00:   w_cnt_init = CNT_W'(31);
            2'b01:   w_cnt_init = CNT_W'(63);
            2'b10:   w_cnt_init = CNT_W'(127);
            default: w_cnt_init = CNT_W'(255);
        endcase
    end

    // One interleaved step: r <- (2r mod p + y[cnt]*x) mod p, carried at MAX_BITS+1.
    assign w_p_ext  = {1'b0, r_p};
    assign w_dbl    = {r_acc, 1'b0};
    assign w_t      = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
    assign w_addend = r_y[r_cnt] ? {1'b0, r_x} : '0;
    assign w_sum    = w_t + w_addend;
    assign w_u      = (w_sum >= w_p_ext) ? MAX_BITS'(w_sum - w_p_ext) : MAX_BITS'(w_sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_p      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mode   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_x     <= i_x & w_in_mask;
                        r_y     <= i_y & w_in_mask;
                        r_p     <= i_prime & w_in_mask;
                        r_mode  <= i_mode;
                        r_acc   <= '0;
                        r_cnt   <= w_cnt_init;
                        o_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_u;
                    if (r_cnt == '0) begin
                        o_result <= w_u & w_run_mask;
                        o_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
